// File: rtl/slice_run_ctrl_pkg.sv
// slice_run_ctrl_pkg
//   Shared definitions for the slice run controller: default sizing,
//   state encoding and a small state-decode helper.
package slice_run_ctrl_pkg;

  localparam int NUM_SLICES_DEF = 16;
  localparam int CNT_W_DEF      = 5;

  // Plain vector encoding so legacy tooling and waveform filters keep working.
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ISSUE  = 3'd1;
  localparam state_t S_WAIT   = 3'd2;
  localparam state_t S_PAUSED = 3'd3;
  localparam state_t S_DRAIN  = 3'd4;
  localparam state_t S_DONE   = 3'd5;

  // A run is "busy" from the first issue until it is idle, done or drained.
  function automatic logic state_busy(input state_t s);
    return (s == S_ISSUE) || (s == S_WAIT) || (s == S_PAUSED) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/slice_run_ctrl_if.sv
// slice_run_ctrl_if
//   Controller <-> slice engine handshake.
//   slice_req_o / slice_idx_o : controller -> engine, request to process a slice
//   slice_ack_i               : engine -> controller, request accepted
//   slice_done_i              : engine -> controller, 1-cycle pulse, slice finished
//   Modports: master = run controller, slave = engine.
interface slice_run_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             slice_req_o;
  logic [CNT_W-1:0] slice_idx_o;
  logic             slice_ack_i;
  logic             slice_done_i;

  modport master (output slice_req_o, slice_idx_o, input  slice_ack_i, slice_done_i);
  modport slave  (input  slice_req_o, slice_idx_o, output slice_ack_i, slice_done_i);
endinterface

// File: rtl/slice_run_ctrl.sv
// slice_run_ctrl
//   Sequences a run of NUM_SLICES slices through the engine, one at a time,
//   driven by start / pause / abort key pulses. All outputs are registered.
// Ports
//   clk, rst_n      clock, async active-low reset
//   start_key_i     start a run (IDLE/DONE) or resume (PAUSED)
//   pause_key_i     toggle pause request (taken at slice boundary) / resume
//   abort_key_i     cancel the run (in-flight slice is drained first)
//   eng             engine handshake (master side)
//   start_o         1-cycle GO pulse on run start or resume
//   pause_o         high while paused
//   finish_o        high while the run is complete
//   slice_num_o     slices completed this run
//   busy_o          high while a run is in progress (incl. pause / drain)
module slice_run_ctrl
  import slice_run_ctrl_pkg::*;
#(
  parameter int NUM_SLICES = NUM_SLICES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_key_i,
  input  logic             pause_key_i,
  input  logic             abort_key_i,
  slice_run_ctrl_if.master eng,
  output logic             start_o,
  output logic             pause_o,
  output logic             finish_o,
  output logic [CNT_W-1:0] slice_num_o,
  output logic             busy_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_d, cnt_inc;
  logic             pend_q, pend_d, pend_tgl, start_d;
  logic             req_q;

  assign cnt_inc  = slice_num_o + 1'b1;
  // A pause press in the same cycle as a boundary counts before the boundary.
  assign pend_tgl = pend_q ^ pause_key_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = slice_num_o;
    pend_d  = pend_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (abort_key_i) begin
          state_d = S_IDLE;
        end else if (start_key_i) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        // Abort here is the only case where an un-acked request may drop.
        if (abort_key_i) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
        end else begin
          pend_d = pend_tgl;
          if (eng.slice_ack_i) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng.slice_done_i) begin
          cnt_d  = cnt_inc;
          pend_d = 1'b0;
          // Abort landing on the done pulse: slice is already finished, no drain.
          if (abort_key_i)                          state_d = S_IDLE;
          else if (cnt_inc == CNT_W'(NUM_SLICES))   state_d = S_DONE;
          else if (pend_tgl)                        state_d = S_PAUSED;
          else                                      state_d = S_ISSUE;
        end else if (abort_key_i) begin
          state_d = S_DRAIN;
          pend_d  = 1'b0;
        end else begin
          pend_d = pend_tgl;
        end
      end
      S_PAUSED: begin
        if (abort_key_i) begin
          state_d = S_IDLE;
        end else if (pause_key_i || start_key_i) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // Keys ignored; the finished slice still counts toward the display.
        if (eng.slice_done_i) begin
          cnt_d   = cnt_inc;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      slice_num_o <= '0;
      pend_q      <= 1'b0;
      start_o     <= 1'b0;
      req_q       <= 1'b0;
      pause_o     <= 1'b0;
      finish_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slice_num_o <= cnt_d;
      pend_q      <= pend_d;
      start_o     <= start_d;
      req_q       <= (state_d == S_ISSUE);
      pause_o     <= (state_d == S_PAUSED);
      finish_o    <= (state_d == S_DONE);
      busy_o      <= state_busy(state_d);
    end
  end

  // The slice being requested/processed is always the next uncompleted one.
  assign eng.slice_req_o = req_q;
  assign eng.slice_idx_o = slice_num_o;

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    eng.slice_req_o && !eng.slice_ack_i && !abort_key_i
      |=> eng.slice_req_o && $stable(eng.slice_idx_o));
  a_status_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(pause_o && finish_o));
  a_num_range: assert property (@(posedge clk) disable iff (!rst_n)
    slice_num_o <= CNT_W'(NUM_SLICES));
  a_done_legal: assert property (@(posedge clk) disable iff (!rst_n)
    eng.slice_done_i |-> (state_q == S_WAIT || state_q == S_DRAIN));

endmodule

// File: tb/tb_slice_run_ctrl.sv
// tb_slice_run_ctrl
//   Directed scenarios (full run, pause, pause cancel, abort, collisions,
//   reset mid-run) followed by random key traffic. An engine responder
//   answers requests; a run-level reference model predicts every output
//   each cycle.
module tb_slice_run_ctrl;
  import slice_run_ctrl_pkg::*;

  localparam int N  = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start_key, pause_key, abort_key;
  logic start_o, pause_o, finish_o, busy_o;
  logic [CW-1:0] slice_num;

  slice_run_ctrl_if #(.CNT_W(CW)) eng_if ();

  slice_run_ctrl #(.NUM_SLICES(N), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_key_i (start_key),
    .pause_key_i (pause_key),
    .abort_key_i (abort_key),
    .eng         (eng_if),
    .start_o     (start_o),
    .pause_o     (pause_o),
    .finish_o    (finish_o),
    .slice_num_o (slice_num),
    .busy_o      (busy_o)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---- run-level reference model ----
  int m_cnt;
  bit m_req, m_fly, m_paused, m_drain, m_fin, m_pend, m_go;

  task automatic model_reset();
    m_cnt = 0; m_req = 0; m_fly = 0; m_paused = 0;
    m_drain = 0; m_fin = 0; m_pend = 0; m_go = 0;
  endtask

  task automatic model_update(input bit ks, input bit kp, input bit ka,
                              input bit ack, input bit done);
    bit p;
    m_go = 0;
    if (m_drain) begin
      if (done) begin m_cnt++; m_drain = 0; end
    end else if (m_req) begin
      if (ka) begin m_req = 0; m_pend = 0; end
      else begin
        if (kp) m_pend = !m_pend;
        if (ack) begin m_req = 0; m_fly = 1; end
      end
    end else if (m_fly) begin
      if (done) begin
        m_fly = 0; m_cnt++;
        p = m_pend ^ kp;
        m_pend = 0;
        if (!ka) begin
          if (m_cnt == N) m_fin = 1;
          else if (p)     m_paused = 1;
          else            m_req = 1;
        end
      end else if (ka) begin
        m_fly = 0; m_drain = 1; m_pend = 0;
      end else if (kp) m_pend = !m_pend;
    end else if (m_paused) begin
      if (ka) m_paused = 0;
      else if (kp || ks) begin m_paused = 0; m_req = 1; m_go = 1; end
    end else begin
      if (ka) m_fin = 0;
      else if (ks) begin m_fin = 0; m_cnt = 0; m_req = 1; m_go = 1; end
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [CW-1:0] mc;
    mc = CW'(m_cnt);
    return {17'd0, m_req, mc, m_go, m_paused, m_fin, mc,
            (m_req | m_fly | m_paused | m_drain)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {17'd0, eng_if.slice_req_o, eng_if.slice_idx_o, start_o, pause_o,
            finish_o, slice_num, busy_o};
  endfunction

  // ---- engine responder ----
  int ack_lat = 1, done_lat = 3, eng_req_cnt = 0, eng_busy = 0;
  bit eng_stall = 0, rnd_lat = 0, pause_on_done = 0, prev_req = 0;
  int n_start = 0;
  int idx_log[$];

  task automatic step(input bit ks, input bit kp, input bit ka);
    bit ack, done;
    @(negedge clk);
    chk("cycle", dut_vec(), model_vec());
    if (start_o) n_start++;
    if (eng_if.slice_req_o && !prev_req) idx_log.push_back(int'(eng_if.slice_idx_o));
    prev_req = eng_if.slice_req_o;
    ack = 0; done = 0;
    if (eng_busy > 0) begin
      eng_busy--;
      if (eng_busy == 0) done = 1;
    end
    if (eng_if.slice_req_o && !eng_stall) begin
      eng_req_cnt++;
      if (eng_req_cnt > ack_lat) begin
        ack = 1; eng_req_cnt = 0;
        eng_busy = rnd_lat ? int'($urandom_range(4, 1)) : done_lat;
        if (rnd_lat) ack_lat = int'($urandom_range(3, 0));
      end
    end else eng_req_cnt = 0;
    if (pause_on_done) kp = done;
    if (ack) ka = 0;   // an accepted slice must be allowed to complete
    start_key = ks; pause_key = kp; abort_key = ka;
    eng_if.slice_ack_i = ack; eng_if.slice_done_i = done;
    if (!rst_n) model_reset();
    else model_update(ks, kp, ka, ack, done);
  endtask

  // Advance until the engine is working on slice idx (request already acked).
  task automatic wait_slice(input int idx, input string tag);
    int i = 0;
    while (!(busy_o && !eng_if.slice_req_o && !pause_o &&
             int'(eng_if.slice_idx_o) == idx) && i < 300) begin
      step(0, 0, 0); i++;
    end
    chk(tag, 32'(i < 300), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    start_key = 0; pause_key = 0; abort_key = 0;
    eng_if.slice_ack_i = 0; eng_if.slice_done_i = 0;
    model_reset();
    repeat (3) step(0, 0, 0);
    chk("rst_state", dut_vec(), 32'd0);
    rst_n = 1'b1;
    step(0, 0, 0);

    // T1 full run
    n_start = 0; idx_log.delete();
    step(1, 0, 0);
    for (int i = 0; i < 400 && !finish_o; i++) step(0, 0, 0);
    chk("t1_finish", 32'(finish_o), 32'd1);
    chk("t1_num", 32'(slice_num), N);
    chk("t1_starts", n_start, 1);
    chk("t1_nreq", idx_log.size(), N);
    for (int i = 0; i < idx_log.size(); i++) chk("t1_idx", idx_log[i], i);

    // T2 pause during slice 5, then resume
    step(1, 0, 0);
    wait_slice(5, "t2_reach5");
    step(0, 1, 0);
    for (int i = 0; i < 50 && !pause_o; i++) step(0, 0, 0);
    chk("t2_num", 32'(slice_num), 32'd6);
    chk("t2_pause", 32'(pause_o), 32'd1);
    chk("t2_noreq", 32'(eng_if.slice_req_o), 32'd0);
    repeat (3) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("t2_go", 32'(start_o), 32'd1);
    chk("t2_req", 32'(eng_if.slice_req_o), 32'd1);
    chk("t2_idx", 32'(eng_if.slice_idx_o), 32'd6);
    for (int i = 0; i < 400 && !finish_o; i++) step(0, 0, 0);

    // T3 pause pressed twice within slice 3
    step(1, 0, 0);
    wait_slice(3, "t3_reach3");
    step(0, 1, 0);
    step(0, 1, 0);
    for (int i = 0; i < 50 && !(eng_if.slice_req_o || pause_o); i++) step(0, 0, 0);
    chk("t3_nopause", 32'(pause_o), 32'd0);
    chk("t3_req", 32'(eng_if.slice_req_o), 32'd1);
    chk("t3_idx", 32'(eng_if.slice_idx_o), 32'd4);

    // T4 abort during slice 7 processing, then abort of an un-acked request
    wait_slice(7, "t4_reach7");
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t4_drain_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 50 && busy_o; i++) step(0, 0, 0);
    chk("t4_num", 32'(slice_num), 32'd8);
    repeat (5) step(0, 0, 0);
    chk("t4_idle_req", 32'(eng_if.slice_req_o), 32'd0);
    eng_stall = 1;
    step(1, 0, 0);
    step(0, 0, 0);
    chk("t4_req_up", 32'(eng_if.slice_req_o), 32'd1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t4_req_drop", 32'(eng_if.slice_req_o), 32'd0);
    chk("t4_idle", 32'(busy_o), 32'd0);
    eng_stall = 0;

    // T5 pause on last done -> DONE; abort+start while paused -> IDLE
    step(1, 0, 0);
    wait_slice(15, "t5_reach15");
    pause_on_done = 1;
    for (int i = 0; i < 20 && !finish_o; i++) step(0, 0, 0);
    pause_on_done = 0;
    chk("t5_finish", 32'(finish_o), 32'd1);
    chk("t5_nopause", 32'(pause_o), 32'd0);
    step(1, 0, 0);
    wait_slice(0, "t5_reach0");
    step(0, 1, 0);
    for (int i = 0; i < 20 && !pause_o; i++) step(0, 0, 0);
    chk("t5_paused", 32'(pause_o), 32'd1);
    step(1, 0, 1);
    step(0, 0, 0);
    chk("t5_abort_idle", {busy_o, pause_o, start_o}, 32'd0);

    // T6 asynchronous reset during slice 9
    step(1, 0, 0);
    wait_slice(9, "t6_reach9");
    #2 rst_n = 1'b0;
    #1 chk("t6_async", dut_vec(), 32'd0);
    model_reset();
    eng_busy = 0; eng_req_cnt = 0; prev_req = 0;
    start_key = 0; pause_key = 0; abort_key = 0;
    eng_if.slice_ack_i = 0; eng_if.slice_done_i = 0;
    repeat (2) step(0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0);
    step(0, 0, 0);
    chk("t6_req", 32'(eng_if.slice_req_o), 32'd1);
    chk("t6_idx", 32'(eng_if.slice_idx_o), 32'd0);

    // Random key traffic with random engine latencies
    rnd_lat = 1;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(19, 0) == 0, $urandom_range(24, 0) == 0,
           $urandom_range(59, 0) == 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
